// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite renderer and its animation control.
package pacman_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned DIFF_W    = 11;
    localparam int unsigned R_W       = 6;
    localparam int unsigned SQ_W      = 12;
    localparam int unsigned KEYCODE_W = 8;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {CLOSED, HALF_OPENING, OPEN, HALF_CLOSING} phase_t;
    typedef enum logic [1:0] {MOUTH_NONE, MOUTH_HALF, MOUTH_FULL} mouth_t;

    localparam logic [KEYCODE_W-1:0] KEY_W = 8'h1a;
    localparam logic [KEYCODE_W-1:0] KEY_A = 8'h04;
    localparam logic [KEYCODE_W-1:0] KEY_S = 8'h16;
    localparam logic [KEYCODE_W-1:0] KEY_D = 8'h07;

    // Stage-1 payload: pixel offset rotated so the mouth always opens along +along.
    typedef struct packed {
        logic signed [DIFF_W-1:0]  along;
        logic        [COORD_W-1:0] perp_abs;
        logic        [R_W-1:0]     r;
        logic                      near;
        mouth_t                    mouth;
        logic                      blank;
    } stage1_t;

    function automatic logic [COORD_W-1:0] mag(input logic signed [DIFF_W-1:0] v);
        logic signed [DIFF_W-1:0] n;
        n = -v;
        return v[DIFF_W-1] ? n[COORD_W-1:0] : v[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/pacman_anim.sv
// Frame counter, mouth-phase FSM and facing-direction register, all advanced by frame_tick.
module pacman_anim
    import pacman_pkg::*;
#(
    parameter int unsigned ANIM_FRAMES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 frame_tick_i,
    input  logic [KEYCODE_W-1:0] keycode_i,
    output dir_t                 dir_o,
    output mouth_t               mouth_o
);

    localparam logic [CNT_W-1:0] FRAMES_LAST = CNT_W'(ANIM_FRAMES - 1);

    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dir_t              dir_q, dir_d;
    mouth_t            mouth_q, mouth_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= CLOSED;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            mouth_q <= MOUTH_NONE;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mouth_q <= mouth_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mouth_d = MOUTH_NONE;

        if (frame_tick_i) begin
            case (keycode_i)
                KEY_W:   dir_d = DIR_UP;
                KEY_A:   dir_d = DIR_LEFT;
                KEY_S:   dir_d = DIR_DOWN;
                KEY_D:   dir_d = DIR_RIGHT;
                default: dir_d = dir_q;
            endcase

            if (cnt_q == FRAMES_LAST) begin
                cnt_d = '0;
                case (phase_q)
                    CLOSED:       phase_d = HALF_OPENING;
                    HALF_OPENING: phase_d = OPEN;
                    OPEN:         phase_d = HALF_CLOSING;
                    HALF_CLOSING: phase_d = CLOSED;
                    default:      phase_d = CLOSED;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Mouth width is registered from the next phase so it tracks phase_q exactly.
        case (phase_d)
            CLOSED:  mouth_d = MOUTH_NONE;
            OPEN:    mouth_d = MOUTH_FULL;
            default: mouth_d = MOUTH_HALF;
        endcase
    end

    assign dir_o   = dir_q;
    assign mouth_o = mouth_q;

endmodule

// File: rtl/pacman_renderer.sv
// Two-stage pixel pipeline deciding whether the scan position is inside Pac-Man's body minus the mouth wedge.
module pacman_renderer
    import pacman_pkg::*;
#(
    parameter int unsigned ANIM_FRAMES = 4,
    parameter int unsigned MAX_R       = 31,
    parameter logic [23:0] PAC_RGB     = 24'hFFFF00
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_tick,
    input  logic [KEYCODE_W-1:0] keycode,
    input  logic [COORD_W-1:0]   BallX,
    input  logic [COORD_W-1:0]   BallY,
    input  logic [COORD_W-1:0]   BallS,
    input  logic [COORD_W-1:0]   DrawX,
    input  logic [COORD_W-1:0]   DrawY,
    input  logic                 blank_in,
    output logic                 blank_out,
    output logic                 is_pac,
    output logic [7:0]           Red,
    output logic [7:0]           Green,
    output logic [7:0]           Blue
);

    dir_t    dir;
    mouth_t  mouth_w;

    pacman_anim #(.ANIM_FRAMES(ANIM_FRAMES)) u_anim (
        .clk_i        (Clk),
        .rst_ni       (Reset_n),
        .frame_tick_i (frame_tick),
        .keycode_i    (keycode),
        .dir_o        (dir),
        .mouth_o      (mouth_w)
    );

    logic signed [DIFF_W-1:0] dx_c, dy_c, along_c;
    logic [COORD_W-1:0]       adx_c, ady_c, perp_c;
    logic [R_W-1:0]           r_c;
    stage1_t                  s1_d, s1_q;

    // Stage 1: signed offsets, radius clamp, bounding-box test and rotation into the facing frame.
    always_comb begin
        dx_c  = $signed({1'b0, DrawX}) - $signed({1'b0, BallX});
        dy_c  = $signed({1'b0, DrawY}) - $signed({1'b0, BallY});
        adx_c = mag(dx_c);
        ady_c = mag(dy_c);
        r_c   = (BallS > COORD_W'(MAX_R)) ? R_W'(MAX_R) : BallS[R_W-1:0];

        along_c = dx_c;
        perp_c  = ady_c;
        case (dir)
            DIR_RIGHT: begin along_c = dx_c;  perp_c = ady_c; end
            DIR_LEFT:  begin along_c = -dx_c; perp_c = ady_c; end
            DIR_DOWN:  begin along_c = dy_c;  perp_c = adx_c; end
            DIR_UP:    begin along_c = -dy_c; perp_c = adx_c; end
            default:   begin along_c = dx_c;  perp_c = ady_c; end
        endcase

        s1_d.along    = along_c;
        s1_d.perp_abs = perp_c;
        s1_d.r        = r_c;
        s1_d.near     = (adx_c <= COORD_W'(r_c)) && (ady_c <= COORD_W'(r_c));
        s1_d.mouth    = mouth_w;
        s1_d.blank    = blank_in;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) s1_q <= '0;
        else          s1_q <= s1_d;
    end

    logic [COORD_W-1:0] along_mag_c;
    logic [SQ_W-1:0]    a2_c, p2_c, r2_c;
    logic [SQ_W:0]      d2_c;
    logic               body_c, along_pos_c, half_in_c, full_in_c, mouth_c, pac_c;

    // Stage 2: circle test on the (small, near-gated) magnitudes and wedge removal.
    always_comb begin
        along_mag_c = mag(s1_q.along);
        a2_c = SQ_W'(along_mag_c[R_W-1:0]) * SQ_W'(along_mag_c[R_W-1:0]);
        p2_c = SQ_W'(s1_q.perp_abs[R_W-1:0]) * SQ_W'(s1_q.perp_abs[R_W-1:0]);
        r2_c = SQ_W'(s1_q.r) * SQ_W'(s1_q.r);
        d2_c = {1'b0, a2_c} + {1'b0, p2_c};
        body_c = s1_q.near && (d2_c <= {1'b0, r2_c});

        along_pos_c = !s1_q.along[DIFF_W-1] && (s1_q.along != '0);
        half_in_c   = {1'b0, s1_q.perp_abs, 1'b0} <= {2'b00, s1_q.along[COORD_W-1:0]};
        full_in_c   = s1_q.perp_abs <= s1_q.along[COORD_W-1:0];

        mouth_c = 1'b0;
        case (s1_q.mouth)
            MOUTH_HALF: mouth_c = along_pos_c && half_in_c;
            MOUTH_FULL: mouth_c = along_pos_c && full_in_c;
            default:    mouth_c = 1'b0;
        endcase

        pac_c = body_c && !mouth_c && s1_q.blank;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_pac    <= 1'b0;
            blank_out <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
        end else begin
            is_pac    <= pac_c;
            blank_out <= s1_q.blank;
            Red       <= pac_c ? PAC_RGB[23:16] : 8'h00;
            Green     <= pac_c ? PAC_RGB[15:8]  : 8'h00;
            Blue      <= pac_c ? PAC_RGB[7:0]   : 8'h00;
        end
    end

endmodule

// File: tb/tb_pacman_renderer.sv
// Directed bench for pacman_renderer: pipeline latency, body/mouth geometry, direction, clamp and reset.
module tb_pacman_renderer;

    logic       Clk;
    logic       Reset_n;
    logic       frame_tick;
    logic [7:0] keycode;
    logic [9:0] BallX, BallY, BallS, DrawX, DrawY;
    logic       blank_in;
    logic       blank_out, is_pac;
    logic [7:0] Red, Green, Blue;

    int vectors;
    int miscompares;

    pacman_renderer #(.ANIM_FRAMES(1), .MAX_R(31), .PAC_RGB(24'hFFFF00)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallS      (BallS),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank_in   (blank_in),
        .blank_out  (blank_out),
        .is_pac     (is_pac),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic b);
        @(negedge Clk);
        DrawX    = x;
        DrawY    = y;
        blank_in = b;
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic exp);
        drive(x, y, 1'b1);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk(tag, {31'd0, is_pac}, {31'd0, exp});
    endtask

    task automatic tick(input logic [7:0] k);
        @(negedge Clk);
        keycode    = k;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset_n     = 1'b1;
        frame_tick  = 1'b0;
        keycode     = 8'h00;
        BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
        DrawX = 10'd320; DrawY = 10'd240; blank_in = 1'b1;

        #1 Reset_n = 1'b0;
        #1;
        chk("reset is_pac", {31'd0, is_pac}, 32'd0);
        chk("reset blank_out", {31'd0, blank_out}, 32'd0);
        chk("reset rgb", {8'd0, Red, Green, Blue}, 32'd0);

        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("centre is_pac", {31'd0, is_pac}, 32'd1);
        chk("centre rgb", {8'd0, Red, Green, Blue}, 32'h00FFFF00);
        chk("centre blank_out", {31'd0, blank_out}, 32'd1);

        // Streamed row scan: each sample shows the pixel driven one iteration earlier.
        for (int i = 0; i <= 21; i++) begin
            @(negedge Clk);
            if (i <= 20) DrawX = 10'(310 + i);
            @(posedge Clk);
            #1;
            if (i >= 1)
                chk($sformatf("row x=%0d", 309 + i), {31'd0, is_pac},
                    {31'd0, ((309 + i) >= 316) && ((309 + i) <= 324)});
        end

        drive(10'd320, 10'd240, 1'b0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("blanked is_pac", {31'd0, is_pac}, 32'd0);
        chk("blanked blank_out", {31'd0, blank_out}, 32'd0);
        chk("blanked red", {24'd0, Red}, 32'd0);

        BallS = 10'd0;
        pix("r0 centre", 10'd320, 10'd240, 1'b1);
        pix("r0 x+1", 10'd321, 10'd240, 1'b0);
        pix("r0 y+1", 10'd320, 10'd241, 1'b0);
        BallS = 10'd4;

        tick(8'h00);
        tick(8'h00);
        pix("open right 323", 10'd323, 10'd240, 1'b0);
        pix("open right 324,241", 10'd324, 10'd241, 1'b0);
        pix("open right centre", 10'd320, 10'd240, 1'b1);
        pix("open right 317", 10'd317, 10'd240, 1'b1);

        @(negedge Clk);
        keycode = 8'h04;
        pix("no-tick key 317", 10'd317, 10'd240, 1'b1);
        pix("no-tick key 323", 10'd323, 10'd240, 1'b0);

        tick(8'h04);
        pix("left half 317", 10'd317, 10'd240, 1'b0);
        pix("left half 323", 10'd323, 10'd240, 1'b1);

        tick(8'h00);
        pix("closed left 317", 10'd317, 10'd240, 1'b1);

        BallS = 10'd200;
        pix("clamp 351", 10'd351, 10'd240, 1'b1);
        pix("clamp 352", 10'd352, 10'd240, 1'b0);
        pix("clamp 289", 10'd289, 10'd240, 1'b1);
        pix("clamp y271", 10'd320, 10'd271, 1'b1);
        pix("clamp y272", 10'd320, 10'd272, 1'b0);

        BallX = 10'd2;
        pix("edge x0", 10'd0, 10'd240, 1'b1);
        pix("edge x1023", 10'd1023, 10'd240, 1'b0);
        pix("edge x33", 10'd33, 10'd240, 1'b1);
        pix("edge x34", 10'd34, 10'd240, 1'b0);

        BallX = 10'd320;
        BallS = 10'd4;
        tick(8'h16);
        pix("down half 320,243", 10'd320, 10'd243, 1'b0);
        pix("down half 320,237", 10'd320, 10'd237, 1'b1);
        pix("down half 321,243", 10'd321, 10'd243, 1'b0);
        pix("down half 322,243", 10'd322, 10'd243, 1'b1);

        tick(8'h1a);
        pix("up open 320,237", 10'd320, 10'd237, 1'b0);
        pix("up open 322,237", 10'd322, 10'd237, 1'b0);
        pix("up open 320,243", 10'd320, 10'd243, 1'b1);

        // Mid-stream reset: outputs must clear without waiting for a clock edge.
        drive(10'd320, 10'd240, 1'b1);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("pre-reset is_pac", {31'd0, is_pac}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async reset is_pac", {31'd0, is_pac}, 32'd0);
        chk("async reset rgb", {8'd0, Red, Green, Blue}, 32'd0);
        chk("async reset blank_out", {31'd0, blank_out}, 32'd0);

        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        DrawX   = 10'd323;
        keycode = 8'h00;
        @(posedge Clk);
        #1;
        chk("post-reset first edge blank_out", {31'd0, blank_out}, 32'd0);
        @(posedge Clk);
        #1;
        chk("post-reset closed 323", {31'd0, is_pac}, 32'd1);

        tick(8'h00);
        tick(8'h00);
        pix("post-reset open right 323,242", 10'd323, 10'd242, 1'b0);
        pix("post-reset open right 320,237", 10'd320, 10'd237, 1'b1);
        pix("post-reset open right 317", 10'd317, 10'd240, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
